updown_count_ctrl: RTL and testbench
====================================

# updown_count_ctrl

Sequencing controller for the 4-bit up/down counter datapath. It accepts a start request with a direction and a terminal limit, then loads the counter's reset value (0 up, all-ones down) and steps it at a programmable prescaled rate until the limit is reached. It supports pause, abort and an acknowledge handshake. It sits between system control logic and the counter, and replaces free-running counters wherever a bounded, restartable count is needed.

## Interface
- WIDTH, 4: counter width in bits.
- DIV, 1: clocks per count step, ≥1; prescaler width is clog2(DIV), minimum 1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clock is clock.
- start  in  1  begin a run; sampled only in IDLE.
- dir  in  1  0 = up, 1 = down; latched on accepted start.
- limit  in  WIDTH  terminal value; latched on accepted start.
- pause  in  1  level; freezes count while high (RUN/HOLD).
- stop  in  1  abort run; RUN/HOLD → IDLE.
- ack  in  1  acknowledge completion; DONE → IDLE.
- count  out  WIDTH  current counter value.
- busy  out  1  high in RUN, HOLD, DONE.
- done  out  1  completion flag (see Configuration).
- state  out  2  IDLE=0, RUN=1, HOLD=2, DONE=3.

## Operation
- Reset (async): state IDLE, count 0, prescaler 0, latched dir/limit 0, busy 0, done 0.
- IDLE: count holds its last value. start=1 latches dir and limit, and loads count with 0 (up) or {WIDTH{1}} (down).
  - If the load value equals limit: next state DONE (zero-length run).
  - Otherwise: next state RUN; the prescaler clears.
- RUN: the prescaler increments each clock. When it equals DIV-1 it clears and count steps +1 (up) or -1 (down).
  - If the stepped value equals the latched limit, the same edge moves to DONE.
  - Limit is always reached without wrap (up from 0, down from all-ones), so no overshoot is possible.
- Priority in RUN/HOLD: stop > pause > step.
  - stop: → IDLE, count and prescaler frozen at current value, done stays 0.
  - pause: RUN → HOLD; nothing advances; a step due that cycle is deferred.
  - pause low in HOLD → RUN; the prescaler resumes from its frozen value.
- DONE: count holds limit, done=1. ack=1 → IDLE. stop also → IDLE. start is ignored.
- start in RUN/HOLD/DONE is ignored. dir and limit changes after acceptance have no effect.

## Timing
- Accepted start at edge k: count = load value, state RUN after edge k.
- n-th step occurs at edge k + n·DIV. An up run to L completes at edge k + L·DIV. A down run completes at edge k + (2^WIDTH-1-L)·DIV.
- done and state=DONE are visible in the same cycle the final step appears on count.
- ack/stop → IDLE: 1 edge. pause takes effect at the next edge.
- Reset mid-run: outputs go to reset values immediately, independent of clock.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro UDCTRL_AUTORELOAD_EN.
- Undefined: behaviour as above. done is a level held in DONE until ack/stop.
- Defined: the DONE state is never entered.
  - On reaching limit, done pulses high for exactly one cycle and state stays RUN.
  - The next step loads the start value (0 / all-ones) instead of ±1, and counting repeats.
  - Only stop or reset returns to IDLE. ack is ignored.
  - Zero-length case: count stays at the load value, with done pulsing every step.

## Test plan
- DIV=1, up, limit=5: start → count 0,1,2,3,4,5 on consecutive edges; done=1 and state=3 with count=5; ack → IDLE, count remains 5, busy=0.
- DIV=3, down, limit=12: count 15 for 3 cycles, 14, 13, then 12 with done at edge k+9.
- DIV=1, up, limit=9: pause high 3 cycles while count=2 → count holds 2, state=2; after release the next edge gives 3; total completion is delayed by exactly 3 cycles.
- Up, limit=10: stop at count=7 → IDLE, count=7, done never asserted. start pulsed mid-run has no effect on count or latched limit.
- Async reset asserted mid-edge-cycle at count=9 → count=0, state=0, busy=0 before the next clock edge. Up, limit=0 → DONE one edge after start.
- UDCTRL_AUTORELOAD_EN, DIV=1, up, limit=3: count 0,1,2,3,0,1,2,3,…; done pulses one cycle each time count=3; ack ignored; stop → IDLE.

Source files
------------

// File: rtl/updown_count_ctrl_if.sv
// Control/status bundle for the up/down counter sequencer.
// master drives requests, slave is the controller.
interface updown_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic             stop;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, dir, limit, pause, stop, ack,
    input  count, busy, done, state
  );

  modport slave (
    input  start, dir, limit, pause, stop, ack,
    output count, busy, done, state
  );
endinterface

// File: rtl/updown_count_ctrl.sv
// Bounded, restartable up/down count sequencer with prescaler.
// UDCTRL_AUTORELOAD_EN: wrap to load value and pulse done.
module updown_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input logic           clock,
  input logic           reset,
  updown_count_ctrl_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] next_val;
  logic             hit;

  // Next-state, count and flag computation
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    hit      = 1'b0;
    next_val = dir_q ? count_q - 1'b1
                     : count_q + 1'b1;
`ifdef UDCTRL_AUTORELOAD_EN
    if (count_q == limit_q)
      next_val = {WIDTH{dir_q}};
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          limit_d = bus.limit;
          count_d = {WIDTH{bus.dir}};
          presc_d = '0;
`ifdef UDCTRL_AUTORELOAD_EN
          state_d = RUN;
`else
          state_d = ({WIDTH{bus.dir}} == bus.limit)
                    ? DONE : RUN;
`endif
        end
      end
      RUN, HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.pause) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
          if (presc_q == PMAX) begin
            presc_d = '0;
            count_d = next_val;
            hit     = (next_val == limit_q);
`ifndef UDCTRL_AUTORELOAD_EN
            if (hit)
              state_d = DONE;
`endif
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.ack || bus.stop)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UDCTRL_AUTORELOAD_EN
    done_d = hit;
`else
    done_d = (state_d == DONE);
`endif
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, async active-high reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench for updown_count_ctrl (DIV=1 and DIV=3).
// Vector table, corner sequences and random run vs model.
module tb_updown_count_ctrl;

  logic clock = 1'b0;
  logic rst1, rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  updown_count_ctrl_if #(.WIDTH(4)) b1();
  updown_count_ctrl_if #(.WIDTH(4)) b3();

  updown_count_ctrl #(.WIDTH(4), .DIV(1)) u1 (
    .clock (clock),
    .reset (rst1),
    .bus   (b1)
  );

  updown_count_ctrl #(.WIDTH(4), .DIV(3)) u3 (
    .clock (clock),
    .reset (rst3),
    .bus   (b3)
  );

  typedef struct {
    logic       s, d;
    logic [3:0] l;
    logic       p, sp, a;
    logic [3:0] c;
    logic [1:0] st;
    logic       dn, bz;
  } vec_t;

  typedef struct {
    int         st;
    logic [3:0] cnt;
    int         ticks;
    logic       d;
    logic [3:0] lim;
    logic       done;
  } mdl_t;

  vec_t tbl[$];

  function automatic vec_t v(int s, int d, int l, int p,
                             int sp, int a, int c, int st,
                             int dn, int bz);
    vec_t r;
    r.s = s[0]; r.d = d[0]; r.l = l[3:0];
    r.p = p[0]; r.sp = sp[0]; r.a = a[0];
    r.c = c[3:0]; r.st = st[1:0];
    r.dn = dn[0]; r.bz = bz[0];
    return r;
  endfunction

  // Reference: one clock of the sequencer, in terms of the
  // behavioural rules (runs, ticks per step, limit test).
  function automatic mdl_t mnext(mdl_t m, int div, logic s,
                                 logic dr, logic [3:0] lm,
                                 logic p, logic sp, logic a);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    case (m.st)
      0: if (s) begin
        n.d = dr;
        n.lim = lm;
        n.cnt = dr ? 4'hF : 4'h0;
        n.ticks = 0;
        n.st = 1;
`ifndef UDCTRL_AUTORELOAD_EN
        if (n.cnt == lm) n.st = 3;
`endif
      end
      1, 2: begin
        if (sp) n.st = 0;
        else if (p) n.st = 2;
        else begin
          n.st = 1;
          n.ticks = m.ticks + 1;
          if (n.ticks == div) begin
            n.ticks = 0;
            if (m.d) n.cnt = m.cnt - 4'd1;
            else n.cnt = m.cnt + 4'd1;
`ifdef UDCTRL_AUTORELOAD_EN
            if (m.cnt == m.lim)
              n.cnt = m.d ? 4'hF : 4'h0;
            if (n.cnt == m.lim) n.done = 1'b1;
`else
            if (n.cnt == m.lim) n.st = 3;
`endif
          end
        end
      end
      default: if (a || sp) n.st = 0;
    endcase
`ifndef UDCTRL_AUTORELOAD_EN
    n.done = (n.st == 3);
`endif
    return n;
  endfunction

  task automatic cmp(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic idle1();
    b1.start = 0; b1.dir = 0; b1.limit = 0;
    b1.pause = 0; b1.stop = 0; b1.ack = 0;
  endtask

  task automatic idle3();
    b3.start = 0; b3.dir = 0; b3.limit = 0;
    b3.pause = 0; b3.stop = 0; b3.ack = 0;
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  mdl_t m1, m3;
  mdl_t mz;

  initial begin
    int exp3[9];
    int rst_st;
    mz = '{st: 0, cnt: 4'h0, ticks: 0, d: 1'b0,
           lim: 4'h0, done: 1'b0};
    idle1();
    idle3();
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    cmp("reset_count", b1.count, 0);
    cmp("reset_state", b1.state, 0);
    cmp("reset_busy", b1.busy, 0);
    cmp("reset_done", b1.done, 0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // s d l p sp a | count state done busy
`ifdef UDCTRL_AUTORELOAD_EN
    tbl.push_back(v(1,0,3,0,0,0, 0,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,1,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,1));
    tbl.push_back(v(0,0,0,0,0,1, 1,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0,1));
    tbl.push_back(v(0,0,0,0,0,1, 3,1,1,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,1));
    tbl.push_back(v(0,0,0,0,1,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,1,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,1,1));
    tbl.push_back(v(0,0,0,0,1,0, 0,0,0,0));
`else
    tbl.push_back(v(1,0,5,0,0,0, 0,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 4,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 5,3,1,1));
    tbl.push_back(v(1,1,9,0,0,0, 5,3,1,1));
    tbl.push_back(v(0,0,0,0,0,1, 5,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,3,1,1));
    tbl.push_back(v(0,0,0,0,1,0, 0,0,0,0));
    tbl.push_back(v(1,1,13,0,0,0, 15,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 14,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 13,3,1,1));
    tbl.push_back(v(1,0,2,0,0,1, 13,0,0,0));
    tbl.push_back(v(1,0,9,0,0,0, 0,1,0,1));
    tbl.push_back(v(1,1,2,0,0,0, 1,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0,1));
    tbl.push_back(v(0,0,0,1,0,0, 2,2,0,1));
    tbl.push_back(v(0,0,0,1,0,0, 2,2,0,1));
    tbl.push_back(v(0,0,0,1,0,0, 2,2,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,1));
    for (int i = 4; i <= 9; i++)
      tbl.push_back(v(0,0,0,0,0,0, i,(i==9)?3:1,
                      (i==9)?1:0,1));
    tbl.push_back(v(0,0,0,0,0,1, 9,0,0,0));
    tbl.push_back(v(1,0,10,0,0,0, 0,1,0,1));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(v(0,0,0,0,0,0, i,1,0,1));
    tbl.push_back(v(0,0,0,0,1,0, 7,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 7,0,0,0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      b1.start = tbl[i].s;
      b1.dir   = tbl[i].d;
      b1.limit = tbl[i].l;
      b1.pause = tbl[i].p;
      b1.stop  = tbl[i].sp;
      b1.ack   = tbl[i].a;
      edge1();
      cmp($sformatf("tbl%0d_count", i), b1.count, tbl[i].c);
      cmp($sformatf("tbl%0d_state", i), b1.state, tbl[i].st);
      cmp($sformatf("tbl%0d_done", i), b1.done, tbl[i].dn);
      cmp($sformatf("tbl%0d_busy", i), b1.busy, tbl[i].bz);
    end
    idle1();

    // DIV=3 down run to 12: three clocks per step
    exp3 = '{15, 15, 14, 14, 14, 13, 13, 13, 12};
    b3.start = 1; b3.dir = 1; b3.limit = 12;
    edge1();
    idle3();
    cmp("div3_load", b3.count, 15);
    cmp("div3_run", b3.state, 1);
    for (int n = 0; n < 9; n++) begin
      edge1();
      cmp($sformatf("div3_e%0d_cnt", n + 1), b3.count,
          exp3[n]);
      cmp($sformatf("div3_e%0d_done", n + 1), b3.done,
          (n == 8) ? 1 : 0);
    end
`ifdef UDCTRL_AUTORELOAD_EN
    rst_st = 1;
`else
    rst_st = 3;
`endif
    cmp("div3_end_state", b3.state, rst_st);
    b3.stop = 1;
    edge1();
    idle3();
    cmp("div3_stop_state", b3.state, 0);

    // Async reset mid-cycle at count 9
    b1.start = 1; b1.dir = 0; b1.limit = 12;
    edge1();
    idle1();
    repeat (9) edge1();
    cmp("prerst_count", b1.count, 9);
    #2;
    rst1 = 1'b1;
    #1;
    cmp("async_rst_count", b1.count, 0);
    cmp("async_rst_state", b1.state, 0);
    cmp("async_rst_busy", b1.busy, 0);
    cmp("async_rst_done", b1.done, 0);
    #2;
    rst1 = 1'b0;

    // Randomized run against the reference model
    rst3 = 1'b1;
    #1;
    rst3 = 1'b0;
    m1 = mz;
    m3 = mz;
    for (int c = 0; c < 3000; c++) begin
      b1.start = ($urandom_range(3) == 0);
      b1.dir   = 1'($urandom_range(1));
      b1.limit = 4'($urandom_range(15));
      b1.pause = ($urandom_range(5) == 0);
      b1.stop  = ($urandom_range(24) == 0);
      b1.ack   = ($urandom_range(3) == 0);
      b3.start = ($urandom_range(3) == 0);
      b3.dir   = 1'($urandom_range(1));
      b3.limit = 4'($urandom_range(15));
      b3.pause = ($urandom_range(5) == 0);
      b3.stop  = ($urandom_range(40) == 0);
      b3.ack   = ($urandom_range(3) == 0);
      m1 = mnext(m1, 1, b1.start, b1.dir, b1.limit,
                 b1.pause, b1.stop, b1.ack);
      m3 = mnext(m3, 3, b3.start, b3.dir, b3.limit,
                 b3.pause, b3.stop, b3.ack);
      edge1();
      cmp("rnd1_count", b1.count, m1.cnt);
      cmp("rnd1_state", b1.state, m1.st);
      cmp("rnd1_done", b1.done, m1.done);
      cmp("rnd1_busy", b1.busy, (m1.st != 0) ? 1 : 0);
      cmp("rnd3_count", b3.count, m3.cnt);
      cmp("rnd3_state", b3.state, m3.st);
      cmp("rnd3_done", b3.done, m3.done);
      cmp("rnd3_busy", b3.busy, (m3.st != 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
